// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Multi-cycle controller that owns the accumulator (AC) and the
//            Z flag and sequences an external combinational ALU. Accepts one
//            command over a valid/ready handshake, holds the opcode and bus
//            operand steady for the whole command, writes the ALU result back
//            into AC once per iteration and repeats cmd_count+1 times.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   reg_width  datapath width of AC, bus operand and ALU result (default 12)
//   cnt_width  width of the repeat-count field (default 4)
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   cmd_valid   in   command present
//   cmd_ready   out  block can accept a command (high only in IDLE)
//   cmd_op      in   3-bit ALU opcode (000 and 111 illegal)
//   cmd_data    in   operand driven on alu_bus for the whole command
//   cmd_count   in   extra repetitions (op runs cmd_count+1 times)
//   alu_op      out  ALU operation code (000 when not executing)
//   alu_bus     out  ALU bus operand
//   alu_ac      out  ALU accumulator input (same as ac_out)
//   alu_result  in   ALU result
//   ac_out      out  current accumulator value
//   z_flag      out  AC == 0 after the most recent AC write
//   done        out  one-cycle pulse at command completion
//   err         out  qualified by done; illegal opcode, AC untouched
//   busy        out  high while executing or completing a command
// Configuration
//   ALU_SEQ_ZSTOP_EN  when defined, an Add or Sub whose result is zero ends
//                     the command early (remaining iterations dropped).
// ============================================================================
module alu_sequencer #(
  parameter int reg_width = 12,
  parameter int cnt_width = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [reg_width-1:0] cmd_data,
  input  logic [cnt_width-1:0] cmd_count,
  output logic [2:0]           alu_op,
  output logic [reg_width-1:0] alu_bus,
  output logic [reg_width-1:0] alu_ac,
  input  logic [reg_width-1:0] alu_result,
  output logic [reg_width-1:0] ac_out,
  output logic                 z_flag,
  output logic                 done,
  output logic                 err,
  output logic                 busy
);

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_BAD  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  logic [reg_width-1:0] ac;
  logic [cnt_width-1:0] iter_cnt;
  logic                 op_legal;
  logic                 zero_stop;
  logic                 last_iter;

  assign ac_out = ac;
  assign alu_ac = ac;

  assign op_legal = (cmd_op != OP_NONE) && (cmd_op != OP_BAD);

  // alu_op holds the latched opcode while executing, so the early-exit test
  // looks at the command's own op rather than the (ignored) cmd_op input.
`ifdef ALU_SEQ_ZSTOP_EN
  assign zero_stop = (alu_result == '0) && ((alu_op == OP_ADD) || (alu_op == OP_SUB));
`else
  assign zero_stop = 1'b0;
`endif

  assign last_iter = (iter_cnt == '0) || zero_stop;

  // Single sequential process: state, datapath registers and all outputs
  // are registered here so nothing on cmd_* reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ac        <= '0;
      z_flag    <= 1'b1;
      iter_cnt  <= '0;
      alu_op    <= OP_NONE;
      alu_bus   <= '0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            alu_bus   <= cmd_data;
            iter_cnt  <= cmd_count;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (op_legal) begin
              alu_op <= cmd_op;
              state  <= S_EXEC;
            end else begin
              // Illegal opcode skips execution entirely; AC and Z untouched.
              alu_op <= OP_NONE;
              done   <= 1'b1;
              err    <= 1'b1;
              state  <= S_DONE;
            end
          end
        end

        S_EXEC: begin
          ac       <= alu_result;
          z_flag   <= (alu_result == '0);
          iter_cnt <= iter_cnt - cnt_width'(1);
          if (last_iter) begin
            alu_op <= OP_NONE;
            done   <= 1'b1;
            err    <= 1'b0;
            state  <= S_DONE;
          end
        end

        S_DONE: begin
          done      <= 1'b0;
          err       <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          alu_op    <= OP_NONE;
          done      <= 1'b0;
          err       <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
